// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 16x oversampling and an internal baud-tick divider.
// It turns the asynchronous rx line into parallel bytes for the host-interface receive stage.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   rx         in   serial line, idle high (asynchronous to clk)
//   rx_data    out  last received byte, held until the next rx_done
//   rx_done    out  one-clock strobe when rx_data/frame_err are updated
//   frame_err  out  stop bit sampled low for the frame just delivered
//   parity_err out  (UART_RX_PARITY_EN only) even-parity mismatch for the frame just delivered
//   busy       out  high whenever the receiver is not idle
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.

module uart_rx_byte #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 19_200,
    parameter int unsigned DBIT     = 8,
    parameter int unsigned OVS      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            busy
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned N_W     = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0]       S_MID    = 4'(OVS / 2 - 1);
    localparam logic [3:0]       S_LAST   = 4'(OVS - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HI
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q;
    logic              rx_s;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              tick;
    logic [3:0]        s_cnt_q, s_cnt_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [DBIT-1:0]   shreg_q, shreg_d;
    logic [DBIT-1:0]   rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              parity_err_q, parity_err_d;
`endif

    // Two-flop synchronizer; the FSM only ever looks at rx_s.
    assign rx_s = sync_q[1];

    // Free-running oversample tick, one clk wide every DIV clocks.
    assign tick      = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and datapath counters.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        shreg_d = shreg_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == S_MID) begin
                        // Still low at mid start bit: real frame, otherwise a glitch.
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        s_cnt_d = '0;
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        par_d   = rx_s;
                        s_cnt_d = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        // A low stop bit may be a break; wait for the line to recover.
                        state_d = rx_s ? ST_IDLE : ST_WAIT_HI;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values, registered below; the byte is delivered even on a framing error.
    always_comb begin
        rx_done_d    = 1'b0;
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        busy_d       = (state_d != ST_IDLE);
        if (state_q == ST_STOP && tick && s_cnt_q == S_LAST) begin
            rx_done_d    = 1'b1;
            rx_data_d    = shreg_q;
            frame_err_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ^{shreg_q, par_q};
`endif
        end
    end

    // Synchronizer, divider, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= 2'b11;
            div_cnt_q    <= '0;
            s_cnt_q      <= '0;
            n_q          <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], rx};
            div_cnt_q    <= div_cnt_d;
            s_cnt_q      <= s_cnt_d;
            n_q          <= n_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
